drag_tree_sequencer: RTL
========================

Name: drag_tree_sequencer

Overview:
- Sequences the start light tree for a two-lane drag race and produces one active-high light-on level per lamp.
- Each light-on output feeds a per-lamp hex light decoder on the DE2 board.
- Tracks staging, rolling-start fouls, per-lane reaction time and the winner.
- Sits between the board buttons/switches (start, stage, finish) and the light decoders.

Parameters:
- TICK_CYCLES, 25000000: clocks per amber step (0.5 s at 50 MHz).
- MS_CYCLES, 50000: clocks per reaction-time count (1 ms at 50 MHz).
- RT_W, 12: reaction counter width in bits; counters saturate.
- TIMEOUT_TICKS, 20: amber-step periods allowed in GREEN before the race is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse, already synchronised and debounced.
- stage  in  2  per-lane staged sensor level; bit 0 = lane 0. 1 = car on line.
- finish  in  2  per-lane finish pulse, one cycle.
- stagedOn  out  2  staged lamps.
- amberOn  out  3  shared amber lamps; bit 0 = top amber.
- greenOn  out  2  per-lane green lamps.
- redOn  out  2  per-lane foul lamps.
- winner  out  2  one-hot winner, 2'b11 = tie, 2'b00 = none.
- react0  out  RT_W  lane 0 reaction time in ms.
- react1  out  RT_W  lane 1 reaction time in ms.
- busy  out  1  high in ARMED, AMBER1..3 and GREEN.
- done  out  1  high in DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset is asynchronous and takes effect mid-race, with no partial outputs retained.
- All outputs are registered: one cycle of latency from any input edge.
- The tick counter runs only in AMBER and GREEN states. It restarts at 0 on every state entry. A tick fires when the count equals TICK_CYCLES-1.
- IDLE: all lamps off. start -> ARMED.
- ARMED:
  - stagedOn follows stage.
  - When stage==2'b11 is sampled, go to AMBER1.
  - start is ignored.
- AMBER1, AMBER2, AMBER3:
  - Exactly one amber lit: bit 0, then bit 1, then bit 2.
  - Each state lasts TICK_CYCLES cycles, then advances; AMBER3 advances to GREEN.
  - A lane whose stage bit reads 0 in any AMBER cycle is fouled: redOn bit set (sticky until the next start) and its stagedOn bit cleared.
  - Both lanes fouled: go to DONE with winner=00.
- GREEN:
  - amberOn=0. greenOn = ~foul; redOn is held.
  - Each non-fouled lane's react counter increments once every MS_CYCLES clocks, from GREEN entry until that lane's stage bit falls. The counter then freezes.
  - Counters saturate at all ones.
  - Finish from a fouled lane is ignored.
  - The first legal finish sets the winner one-hot and goes to DONE.
  - Legal finishes on both lanes in the same cycle set winner=11.
  - After TIMEOUT_TICKS ticks with no legal finish: DONE, winner=00.
- DONE:
  - Lamps, winner and react values held; done=1.
  - start -> ARMED: clears winner, react, redOn, greenOn and amberOn in that same edge.
- A start pulse in any state other than IDLE or DONE has no effect.

Optional Feature:
- Macro PRO_TREE_EN.
- Defined: AMBER1..3 are replaced by a single AMBER state lasting TICK_CYCLES, with amberOn=3'b111, then GREEN. Foul rules are unchanged.
- Undefined: sequential (sportsman) three-step tree as described above.

Test Plan:
- Bench parameters for all scenarios: TICK_CYCLES=4, MS_CYCLES=2, TIMEOUT_TICKS=3.
- Nominal race: reset, start, stage=11 -> amberOn 001, 010, 100, each held 4 cycles. greenOn=11 at cycle 13 after staging. Drop stage0 5 cycles into GREEN and stage1 9 cycles in -> react0=2, react1=4. finish=01 -> winner=01, done=1, busy=0.
- Red light: during AMBER2 drop stage[1] -> redOn=10 and stagedOn[1]=0. Green shows greenOn=01 only. finish=10 then 01 -> winner=01.
- Double foul: drop both stage bits in AMBER1 -> redOn=11, DONE next cycle, winner=00.
- Tie and timeout: finish=11 in the same GREEN cycle -> winner=11. Separate run with no finish -> DONE after 12 GREEN cycles, winner=00.
- Reset and restart:
  - Assert rst_n=0 mid-AMBER2 -> all outputs 0 immediately.
  - From DONE, start -> ARMED with winner, react0/1 and redOn cleared.
  - start while busy has no effect.
- PRO_TREE_EN build: stage=11 -> amberOn=111 for 4 cycles, then greenOn=11.

Source files
------------

// File: rtl/drag_tree_sequencer.sv
// drag_tree_sequencer: start-light tree sequencer for a two-lane drag race.
// Drives per-lamp light-on levels (staged, amber, green, red), tracks
// rolling-start fouls, per-lane reaction time in ms and the race winner.
// All outputs are registered (one cycle of latency from any input).
// Optional feature macro: PRO_TREE_EN -- when defined, the three sequential
// amber steps are replaced by one AMBER step with all three ambers lit.
module drag_tree_sequencer #(
    parameter int TICK_CYCLES   = 25000000,
    parameter int MS_CYCLES     = 50000,
    parameter int RT_W          = 12,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_stage,
    input  logic [1:0]      i_finish,
    output logic [1:0]      o_staged_on,
    output logic [2:0]      o_amber_on,
    output logic [1:0]      o_green_on,
    output logic [1:0]      o_red_on,
    output logic [1:0]      o_winner,
    output logic [RT_W-1:0] o_react0,
    output logic [RT_W-1:0] o_react1,
    output logic            o_busy,
    output logic            o_done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int MS_W   = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

`ifdef PRO_TREE_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_ARMED, ST_AMBER, ST_GREEN, ST_DONE
    } state_t;
    localparam state_t AMBER_FIRST = ST_AMBER;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_ARMED, ST_AMBER1, ST_AMBER2, ST_AMBER3, ST_GREEN, ST_DONE
    } state_t;
    localparam state_t AMBER_FIRST = ST_AMBER1;
`endif

    // Lamp pattern shown while in a given amber state.
    function automatic logic [2:0] amber_lamp(input state_t s);
`ifdef PRO_TREE_EN
        amber_lamp = (s == ST_AMBER) ? 3'b111 : 3'b000;
`else
        case (s)
            ST_AMBER1: amber_lamp = 3'b001;
            ST_AMBER2: amber_lamp = 3'b010;
            ST_AMBER3: amber_lamp = 3'b100;
            default:   amber_lamp = 3'b000;
        endcase
`endif
    endfunction

    // State that follows an amber state when its step period expires.
    function automatic state_t amber_advance(input state_t s);
`ifdef PRO_TREE_EN
        amber_advance = (s == ST_AMBER) ? ST_GREEN : ST_IDLE;
`else
        case (s)
            ST_AMBER1: amber_advance = ST_AMBER2;
            ST_AMBER2: amber_advance = ST_AMBER3;
            default:   amber_advance = ST_GREEN;
        endcase
`endif
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    state_t          w_adv_state;
    logic [TICK_W-1:0] r_tick;
    logic [MS_W-1:0] r_ms;
    logic [TO_W-1:0] r_tocnt;
    logic [1:0]      r_run;
    logic [1:0]      w_run_next;
    logic [RT_W-1:0] r_react [2];

    logic [1:0] r_staged, w_staged_next;
    logic [2:0] r_amber,  w_amber_next;
    logic [1:0] r_green,  w_green_next;
    logic [1:0] r_red,    w_red_next;
    logic [1:0] r_winner, w_winner_next;
    logic       r_busy,   r_done;
    logic       w_react_clr;

    logic       w_tick;
    logic       w_ms_tick;
    logic       w_in_amber;
    logic       w_state_chg;
    logic [1:0] w_legal;
    logic [1:0] w_foul;

    assign w_tick      = (r_tick == TICK_LAST);
    assign w_ms_tick   = (r_ms == MS_LAST);
    assign w_state_chg = (w_state_next != r_state);
    assign w_legal     = i_finish & ~r_red;
    assign w_foul      = r_red | ~i_stage;
    assign w_adv_state = amber_advance(r_state);
`ifdef PRO_TREE_EN
    assign w_in_amber  = (r_state == ST_AMBER);
`else
    assign w_in_amber  = (r_state == ST_AMBER1) || (r_state == ST_AMBER2) ||
                         (r_state == ST_AMBER3);
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state and next lamp/winner values; lamps hold unless changed here.
    always_comb begin
        w_state_next  = r_state;
        w_staged_next = r_staged;
        w_amber_next  = r_amber;
        w_green_next  = r_green;
        w_red_next    = r_red;
        w_winner_next = r_winner;
        w_run_next    = r_run;
        w_react_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next  = ST_ARMED;
                    w_staged_next = i_stage;
                end
            end
            ST_ARMED: begin
                w_staged_next = i_stage;
                if (i_stage == 2'b11) begin
                    w_state_next = AMBER_FIRST;
                    w_amber_next = amber_lamp(AMBER_FIRST);
                end
            end
            ST_GREEN: begin
                w_run_next = r_run & i_stage;
                if (|w_legal) begin
                    w_winner_next = w_legal;
                    w_state_next  = ST_DONE;
                end else if (w_tick && (r_tocnt == TO_LAST)) begin
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_state_next  = ST_ARMED;
                    w_staged_next = i_stage;
                    w_winner_next = 2'b00;
                    w_react_clr   = 1'b1;
                    w_red_next    = 2'b00;
                    w_green_next  = 2'b00;
                    w_amber_next  = 3'b000;
                end
            end
            default: begin
                // Amber steps: any lane off its line is fouled for this race.
                w_red_next    = w_foul;
                w_staged_next = r_staged & ~w_foul;
                if (w_foul == 2'b11) begin
                    w_state_next = ST_DONE;
                end else if (w_tick) begin
                    w_state_next = w_adv_state;
                    if (w_adv_state == ST_GREEN) begin
                        w_amber_next = 3'b000;
                        w_green_next = ~w_foul;
                        w_run_next   = ~w_foul;
                    end else begin
                        w_amber_next = amber_lamp(w_adv_state);
                    end
                end
            end
        endcase
    end

    // Registered lamp, winner and status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_staged <= 2'b00;
            r_amber  <= 3'b000;
            r_green  <= 2'b00;
            r_red    <= 2'b00;
            r_winner <= 2'b00;
            r_run    <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_staged <= w_staged_next;
            r_amber  <= w_amber_next;
            r_green  <= w_green_next;
            r_red    <= w_red_next;
            r_winner <= w_winner_next;
            r_run    <= w_run_next;
            r_busy   <= (w_state_next == ST_ARMED) || (w_state_next == ST_GREEN) ||
                        ((w_state_next != ST_IDLE) && (w_state_next != ST_DONE));
            r_done   <= (w_state_next == ST_DONE);
        end
    end

    // Step, millisecond and timeout counters; all restart on any state change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick  <= '0;
            r_ms    <= '0;
            r_tocnt <= '0;
        end else if (w_state_chg) begin
            r_tick  <= '0;
            r_ms    <= '0;
            r_tocnt <= '0;
        end else begin
            if (w_in_amber || (r_state == ST_GREEN))
                r_tick <= w_tick ? '0 : r_tick + 1'b1;
            else
                r_tick <= '0;
            if (r_state == ST_GREEN) begin
                r_ms <= w_ms_tick ? '0 : r_ms + 1'b1;
                if (w_tick) r_tocnt <= r_tocnt + 1'b1;
            end else begin
                r_ms    <= '0;
                r_tocnt <= '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            // Reaction counter: counts ms while the lane is still on its line.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_react[gi] <= '0;
                else if (w_react_clr)
                    r_react[gi] <= '0;
                else if ((r_state == ST_GREEN) && w_ms_tick && r_run[gi] &&
                         i_stage[gi] && (r_react[gi] != {RT_W{1'b1}}))
                    r_react[gi] <= r_react[gi] + 1'b1;
            end
        end
    endgenerate

    assign o_staged_on = r_staged;
    assign o_amber_on  = r_amber;
    assign o_green_on  = r_green;
    assign o_red_on    = r_red;
    assign o_winner    = r_winner;
    assign o_react0    = r_react[0];
    assign o_react1    = r_react[1];
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
